// File: rtl/ssd_scan_ctrl_if.sv
// Game-side bundle for the seven-segment scanner: glyph loading, status and
// the anode/cathode drive lines.
interface ssd_scan_ctrl_if #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned BR_W     = 4
);
  logic [5*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blink_mask;
  logic [BR_W-1:0]       brightness;
  logic                  load;
  logic                  pending;
  logic                  frame_tick;
  logic [N_DIGITS-1:0]   An;
  logic [7:0]            cathodes;

  modport master (
    output digits_in, dp_in, blink_mask, brightness, load,
    input  pending, frame_tick, An, cathodes
  );

  modport slave (
    input  digits_in, dp_in, blink_mask, brightness, load,
    output pending, frame_tick, An, cathodes
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with PWM brightness, per-digit
// blink and double-buffered glyph loading applied only at frame boundaries.
module ssd_scan_ctrl #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned SCAN_W   = 17,
  parameter int unsigned BR_W     = 4,
  parameter int unsigned BLINK_W  = 6
) (
  input  logic             board_clk,
  input  logic             Reset,
  ssd_scan_ctrl_if.slave   bus
);

  localparam int unsigned IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [4:0]  GLYPH_OFF = 5'h10;

  // Glyph code to active-low {a,b,c,d,e,f,g}; unused codes render blank.
  function automatic logic [6:0] seg_decode(input logic [4:0] g);
    logic [6:0] s;
    case (g)
      5'h00: s = 7'b0000001;
      5'h01: s = 7'b1001111;
      5'h02: s = 7'b0010010;
      5'h03: s = 7'b0000110;
      5'h04: s = 7'b1001100;
      5'h05: s = 7'b0100100;
      5'h06: s = 7'b0100000;
      5'h07: s = 7'b0001111;
      5'h08: s = 7'b0000000;
      5'h09: s = 7'b0000100;
      5'h0A: s = 7'b0001000;
      5'h0B: s = 7'b1100000;
      5'h0C: s = 7'b0110001;
      5'h0D: s = 7'b1000010;
      5'h0E: s = 7'b0110000;
      5'h0F: s = 7'b0111000;
      5'h11: s = 7'b1000100;
      5'h12: s = 7'b0000010;
      5'h13: s = 7'b1110001;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [SCAN_W-1:0]             pre_q,     pre_d;
  logic [IDX_W-1:0]              idx_q,     idx_d;
  logic [BLINK_W-1:0]            blink_q,   blink_d;
  logic [N_DIGITS-1:0][4:0]      sh_dig_q,  sh_dig_d;
  logic [N_DIGITS-1:0]           sh_dp_q,   sh_dp_d;
  logic [N_DIGITS-1:0]           sh_blk_q,  sh_blk_d;
  logic [N_DIGITS-1:0][4:0]      act_dig_q, act_dig_d;
  logic [N_DIGITS-1:0]           act_dp_q,  act_dp_d;
  logic [N_DIGITS-1:0]           act_blk_q, act_blk_d;
  logic                          pend_q,    pend_d;
  logic                          ft_q,      ft_d;
  logic [N_DIGITS-1:0]           an_q,      an_d;
  logic [7:0]                    cat_q,     cat_d;

  logic              slot_end;
  logic              frame_end;
  logic [BR_W-1:0]   upper;
  logic              digit_en;
  logic              blank;
  logic [4:0]        glyph;

  always_comb begin
    slot_end  = &pre_q;
    frame_end = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));

    pre_d     = pre_q + SCAN_W'(1);
    idx_d     = idx_q;
    blink_d   = blink_q;
    sh_dig_d  = sh_dig_q;
    sh_dp_d   = sh_dp_q;
    sh_blk_d  = sh_blk_q;
    act_dig_d = act_dig_q;
    act_dp_d  = act_dp_q;
    act_blk_d = act_blk_q;
    pend_d    = pend_q;
    ft_d      = frame_end;
    an_d      = '1;
    cat_d     = 8'hFF;

    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
    end
    if (frame_end) begin
      blink_d = blink_q + BLINK_W'(1);
    end

    // Shadow is promoted first so a coincident load lands in the shadow and
    // waits a full frame.
    if (frame_end && pend_q) begin
      act_dig_d = sh_dig_q;
      act_dp_d  = sh_dp_q;
      act_blk_d = sh_blk_q;
      pend_d    = 1'b0;
    end
    if (bus.load) begin
      sh_dig_d = bus.digits_in;
      sh_dp_d  = bus.dp_in;
      sh_blk_d = bus.blink_mask;
      pend_d   = 1'b1;
    end

    upper    = pre_q[SCAN_W-1 -: BR_W];
    digit_en = (upper <= bus.brightness);
    glyph    = act_dig_q[idx_q];
    blank    = !digit_en || (act_blk_q[idx_q] && blink_q[BLINK_W-1]);

    if (!blank) begin
      an_d  = ~(N_DIGITS'(1) << idx_q);
      cat_d = {seg_decode(glyph), ~act_dp_q[idx_q]};
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      pre_q     <= '0;
      idx_q     <= '0;
      blink_q   <= '0;
      sh_dig_q  <= {N_DIGITS{GLYPH_OFF}};
      sh_dp_q   <= '0;
      sh_blk_q  <= '0;
      act_dig_q <= {N_DIGITS{GLYPH_OFF}};
      act_dp_q  <= '0;
      act_blk_q <= '0;
      pend_q    <= 1'b0;
      ft_q      <= 1'b0;
      an_q      <= '1;
      cat_q     <= 8'hFF;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      blink_q   <= blink_d;
      sh_dig_q  <= sh_dig_d;
      sh_dp_q   <= sh_dp_d;
      sh_blk_q  <= sh_blk_d;
      act_dig_q <= act_dig_d;
      act_dp_q  <= act_dp_d;
      act_blk_q <= act_blk_d;
      pend_q    <= pend_d;
      ft_q      <= ft_d;
      an_q      <= an_d;
      cat_q     <= cat_d;
    end
  end

  assign bus.pending    = pend_q;
  assign bus.frame_tick = ft_q;
  assign bus.An         = an_q;
  assign bus.cathodes   = cat_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl (8 digits, 32-cycle slots, 4-frame blink)
// with a cycle-indexed reference model feeding an expected-value queue.
module tb_ssd_scan_ctrl;

  logic board_clk = 1'b0;
  logic Reset;

  ssd_scan_ctrl_if #(.N_DIGITS(8), .BR_W(4)) bus ();

  ssd_scan_ctrl #(
    .N_DIGITS(8), .SCAN_W(5), .BR_W(4), .BLINK_W(2)
  ) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 board_clk = ~board_clk;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] cat;
    logic       pend;
    logic       ft;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passes = 0;

  int unsigned cnt;
  int          cyc;
  int          last_ft;
  int          low_cnt;
  logic [4:0]  m_act_dig [8];
  logic [4:0]  m_sh_dig  [8];
  logic [7:0]  m_act_dp, m_sh_dp, m_act_blk, m_sh_blk;
  logic        m_pend;

  function automatic logic [6:0] seg7(input logic [4:0] g);
    case (g)
      5'h00: return 7'b0000001;  5'h01: return 7'b1001111;
      5'h02: return 7'b0010010;  5'h03: return 7'b0000110;
      5'h04: return 7'b1001100;  5'h05: return 7'b0100100;
      5'h06: return 7'b0100000;  5'h07: return 7'b0001111;
      5'h08: return 7'b0000000;  5'h09: return 7'b0000100;
      5'h0A: return 7'b0001000;  5'h0B: return 7'b1100000;
      5'h0C: return 7'b0110001;  5'h0D: return 7'b1000010;
      5'h0E: return 7'b0110000;  5'h0F: return 7'b0111000;
      5'h11: return 7'b1000100;  5'h12: return 7'b0000010;
      5'h13: return 7'b1110001;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      m_act_dig[i] = 5'h10;
      m_sh_dig[i]  = 5'h10;
    end
    m_act_dp = '0; m_sh_dp = '0; m_act_blk = '0; m_sh_blk = '0;
    m_pend = 1'b0;
    last_ft = -1;
    sb.delete();
  endtask

  // One clock: predict what the edge produces, push it, clock, pop and compare.
  task automatic step();
    exp_t        e;
    int unsigned p, ix;
    bit          fe, en, blank;
    p     = cnt % 32;
    ix    = (cnt / 32) % 8;
    fe    = (cnt % 256) == 255;
    en    = (p / 2) <= int'(bus.brightness);
    blank = !en || (m_act_blk[ix] && ((cnt / 512) % 2 == 1));
    e.an  = blank ? 8'hFF : ~(8'd1 << ix);
    e.cat = blank ? 8'hFF : {seg7(m_act_dig[ix]), ~m_act_dp[ix]};
    e.ft  = fe;
    if (fe && m_pend) begin
      for (int i = 0; i < 8; i++) m_act_dig[i] = m_sh_dig[i];
      m_act_dp = m_sh_dp; m_act_blk = m_sh_blk; m_pend = 1'b0;
    end
    if (bus.load) begin
      for (int i = 0; i < 8; i++) m_sh_dig[i] = bus.digits_in[5*i +: 5];
      m_sh_dp = bus.dp_in; m_sh_blk = bus.blink_mask; m_pend = 1'b1;
    end
    e.pend = m_pend;
    sb.push_back(e);
    @(posedge board_clk); #1;
    cnt++;
    cyc++;
    e = sb.pop_front();
    chk("An",         32'(bus.An),         32'(e.an));
    chk("cathodes",   32'(bus.cathodes),   32'(e.cat));
    chk("pending",    32'(bus.pending),    32'(e.pend));
    chk("frame_tick", 32'(bus.frame_tick), 32'(e.ft));
    if (bus.An !== 8'hFF) low_cnt++;
    if (bus.frame_tick === 1'b1) begin
      if (last_ft >= 0) chk("frame_period", 32'(cyc - last_ft), 32'd256);
      last_ft = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [39:0] d, input logic [7:0] dp, input logic [7:0] bm);
    bus.digits_in  = d;
    bus.dp_in      = dp;
    bus.blink_mask = bm;
    bus.load       = 1'b1;
    step();
    bus.load       = 1'b0;
  endtask

  task automatic align_frame_end();
    for (int i = 0; i < 256 && (cnt % 256) != 255; i++) step();
  endtask

  initial begin
    cyc = 0; low_cnt = 0;
    Reset = 1'b1;
    bus.digits_in = '0; bus.dp_in = '0; bus.blink_mask = '0;
    bus.brightness = 4'hF; bus.load = 1'b0;
    model_reset();
    repeat (3) @(posedge board_clk);
    #1;
    chk("rst_An",       32'(bus.An),         32'hFF);
    chk("rst_cathodes", 32'(bus.cathodes),   32'hFF);
    chk("rst_pending",  32'(bus.pending),    32'h0);
    chk("rst_ftick",    32'(bus.frame_tick), 32'h0);
    Reset = 1'b0;

    // No load yet: every slot shows the OFF glyph.
    run(300);

    // Digits 0..7, no decimal points, full brightness.
    do_load({5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 8'h00, 8'h00);
    chk("pending_after_load", 32'(bus.pending), 32'h1);
    run(700);

    // PWM duty: 2/32 and 16/32 of every slot over a whole frame.
    bus.brightness = 4'h0;
    step();
    low_cnt = 0;
    run(256);
    chk("duty_br0", 32'(low_cnt), 32'd16);
    bus.brightness = 4'h7;
    step();
    low_cnt = 0;
    run(256);
    chk("duty_br7", 32'(low_cnt), 32'd128);
    bus.brightness = 4'hF;

    // Load A on the frame_end cycle, overwrite with B three cycles later.
    align_frame_end();
    do_load({8{5'h12}}, 8'hFF, 8'h00);
    step(); step();
    do_load({5'h11, 5'hE, 5'hD, 5'hC, 5'hB, 5'hA, 5'h9, 5'h8}, 8'h0F, 8'h00);
    run(600);

    // Blink digit 0: two frames on, two frames off.
    do_load({5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 8'h00, 8'h01);
    run(1300);

    // L with dp, unused codes with and without dp.
    do_load({5'hF, 5'h1F, 5'h14, 5'h10, 5'h3, 5'h1A, 5'h1A, 5'h13}, 8'b0001_0101, 8'h00);
    run(520);

    // Pending load followed by reset mid-slot: the load must be discarded.
    do_load({8{5'h8}}, 8'hFF, 8'h00);
    run(13);
    Reset = 1'b1;
    #1;
    chk("async_rst_An",       32'(bus.An),       32'hFF);
    chk("async_rst_cathodes", 32'(bus.cathodes), 32'hFF);
    chk("async_rst_pending",  32'(bus.pending),  32'h0);
    @(posedge board_clk); #1;
    chk("rst_edge_An",        32'(bus.An),       32'hFF);
    model_reset();
    Reset = 1'b0;
    run(600);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
